// File: rtl/lu_cmp_collect_if.sv
// Handshake bundle for lu_cmp_collect: comparator results in, {sel,res} entries out.
interface lu_cmp_collect_if;
  logic in_valid;
  logic in_ready;
  logic in_res;
  logic in_sel;
  logic out_valid;
  logic out_ready;
  logic out_res;
  logic out_sel;

  modport master (
    output in_valid, in_res, in_sel, out_ready,
    input  in_ready, out_valid, out_res, out_sel
  );

  modport slave (
    input  in_valid, in_res, in_sel, out_ready,
    output in_ready, out_valid, out_res, out_sel
  );
endinterface

// File: rtl/lu_cmp_collect.sv
// First-word-fall-through FIFO collecting {sel,res} comparator results.
// Optional saturating hit counters are enabled with macro CMP_HIT_COUNT_EN.
module lu_cmp_collect #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  lu_cmp_collect_if.slave         bus,
  output logic [$clog2(DEPTH):0]  level
`ifdef CMP_HIT_COUNT_EN
  ,
  output logic [7:0]              eq_hits,
  output logic [7:0]              neq_hits
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          in_ready_w, out_valid_w, push, pop;
  logic [1:0]    head;

  // Handshake flags depend on registered level only; no path from out_ready to in_ready.
  assign in_ready_w  = (level_q != LW'(DEPTH));
  assign out_valid_w = (level_q != '0);
  assign push        = bus.in_valid & in_ready_w;
  assign pop         = out_valid_w & bus.out_ready;
  assign head        = mem_q[rd_ptr_q];

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_res   = out_valid_w & head[0];
  assign bus.out_sel   = out_valid_w & head[1];
  assign level         = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (!clr && push) mem_q[wr_ptr_q] <= {bus.in_sel, bus.in_res};
    end
  end

`ifdef CMP_HIT_COUNT_EN
  logic [7:0] eq_hits_q, eq_hits_d;
  logic [7:0] neq_hits_q, neq_hits_d;

  // Counters saturate at 255 and only move on accepted pushes.
  always_comb begin
    eq_hits_d  = eq_hits_q;
    neq_hits_d = neq_hits_q;
    if (clr) begin
      eq_hits_d  = '0;
      neq_hits_d = '0;
    end else if (push && bus.in_res) begin
      if (!bus.in_sel && eq_hits_q != 8'hFF)  eq_hits_d  = eq_hits_q + 8'd1;
      if (bus.in_sel && neq_hits_q != 8'hFF)  neq_hits_d = neq_hits_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_hits_q  <= '0;
      neq_hits_q <= '0;
    end else begin
      eq_hits_q  <= eq_hits_d;
      neq_hits_q <= neq_hits_d;
    end
  end

  assign eq_hits  = eq_hits_q;
  assign neq_hits = neq_hits_q;
`endif
endmodule

// File: tb/tb_lu_cmp_collect.sv
// Directed, table-driven bench for lu_cmp_collect (DEPTH=4); counter checks run
// only when CMP_HIT_COUNT_EN is defined.
module tb_lu_cmp_collect;
  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [2:0] level;
`ifdef CMP_HIT_COUNT_EN
  logic [7:0] eq_hits;
  logic [7:0] neq_hits;
`endif

  int total = 0;
  int bad   = 0;

  lu_cmp_collect_if bus ();

  lu_cmp_collect #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .bus      (bus.slave),
    .level    (level)
`ifdef CMP_HIT_COUNT_EN
    ,
    .eq_hits  (eq_hits),
    .neq_hits (neq_hits)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       c, iv, r, s, o;
    logic [2:0] e_lv;
    logic       e_ov, e_ir, e_r, e_s;
  } vec_t;

  vec_t vecs [26];

  function automatic vec_t mk(input int c, input int iv, input int r, input int s,
                              input int o, input int lv, input int ov, input int ir,
                              input int er, input int es);
    vec_t v;
    v.c = 1'(c); v.iv = 1'(iv); v.r = 1'(r); v.s = 1'(s); v.o = 1'(o);
    v.e_lv = 3'(lv); v.e_ov = 1'(ov); v.e_ir = 1'(ir); v.e_r = 1'(er); v.e_s = 1'(es);
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int lv, input int ov, input int ir,
                            input int r, input int s);
    check({tag, " level"},     int'(level),         lv);
    check({tag, " out_valid"}, int'(bus.out_valid), ov);
    check({tag, " in_ready"},  int'(bus.in_ready),  ir);
    check({tag, " out_res"},   int'(bus.out_res),   r);
    check({tag, " out_sel"},   int'(bus.out_sel),   s);
  endtask

  task automatic drive(input int c, input int iv, input int r, input int s, input int o);
    clr           = 1'(c);
    bus.in_valid  = 1'(iv);
    bus.in_res    = 1'(r);
    bus.in_sel    = 1'(s);
    bus.out_ready = 1'(o);
  endtask

  initial begin
    //                 clr iv r  s  ordy lvl ov ir er es
    // fill without popping, then a refused push at full level
    vecs[0]  = mk(0, 1, 1, 0, 0,  1, 1, 1, 1, 0);
    vecs[1]  = mk(0, 1, 0, 1, 0,  2, 1, 1, 1, 0);
    vecs[2]  = mk(0, 1, 0, 0, 0,  3, 1, 1, 1, 0);
    vecs[3]  = mk(0, 1, 1, 1, 0,  4, 1, 0, 1, 0);
    vecs[4]  = mk(0, 1, 0, 1, 0,  4, 1, 0, 1, 0);
    // drain in push order
    vecs[5]  = mk(0, 0, 0, 0, 1,  3, 1, 1, 0, 1);
    vecs[6]  = mk(0, 0, 0, 0, 1,  2, 1, 1, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 1,  1, 1, 1, 1, 1);
    vecs[8]  = mk(0, 0, 0, 0, 1,  0, 0, 1, 0, 0);
    // streaming from empty: push-only first, then push+pop holds level at 1
    vecs[9]  = mk(0, 1, 1, 0, 1,  1, 1, 1, 1, 0);
    vecs[10] = mk(0, 1, 0, 1, 1,  1, 1, 1, 0, 1);
    vecs[11] = mk(0, 1, 1, 1, 1,  1, 1, 1, 1, 1);
    vecs[12] = mk(0, 0, 0, 0, 1,  0, 0, 1, 0, 0);
    // refill, then push+pop at full: pop only
    vecs[13] = mk(0, 1, 1, 0, 0,  1, 1, 1, 1, 0);
    vecs[14] = mk(0, 1, 0, 0, 0,  2, 1, 1, 1, 0);
    vecs[15] = mk(0, 1, 0, 1, 0,  3, 1, 1, 1, 0);
    vecs[16] = mk(0, 1, 1, 1, 0,  4, 1, 0, 1, 0);
    vecs[17] = mk(0, 1, 0, 0, 1,  3, 1, 1, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 1,  2, 1, 1, 0, 1);
    vecs[19] = mk(0, 0, 0, 0, 1,  1, 1, 1, 1, 1);
    // back to level 3, then clr with an offered entry
    vecs[20] = mk(0, 1, 0, 0, 0,  2, 1, 1, 1, 1);
    vecs[21] = mk(0, 1, 1, 0, 0,  3, 1, 1, 1, 1);
    vecs[22] = mk(1, 1, 1, 1, 0,  0, 0, 1, 0, 0);
    vecs[23] = mk(0, 0, 0, 0, 0,  0, 0, 1, 0, 0);
    vecs[24] = mk(0, 1, 0, 1, 0,  1, 1, 1, 0, 1);
    vecs[25] = mk(0, 0, 0, 0, 1,  0, 0, 1, 0, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #1;
    check_outs("reset", 0, 0, 1, 0, 0);
`ifdef CMP_HIT_COUNT_EN
    check("reset eq_hits",  int'(eq_hits),  0);
    check("reset neq_hits", int'(neq_hits), 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      drive(int'(vecs[i].c), int'(vecs[i].iv), int'(vecs[i].r), int'(vecs[i].s), int'(vecs[i].o));
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), int'(vecs[i].e_lv), int'(vecs[i].e_ov),
                 int'(vecs[i].e_ir), int'(vecs[i].e_r), int'(vecs[i].e_s));
    end

`ifdef CMP_HIT_COUNT_EN
    drive(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("cnt clr eq_hits", int'(eq_hits), 0);
    drive(0, 1, 1, 0, 1);
    repeat (10) @(posedge clk);
    #1;
    check("cnt eq_hits after 10", int'(eq_hits), 10);
    repeat (290) @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 1);
    check("cnt eq_hits sat",   int'(eq_hits),  255);
    check("cnt neq_hits zero", int'(neq_hits), 0);
    drive(0, 1, 1, 1, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1);
    check("cnt neq_hits one", int'(neq_hits), 1);
    check("cnt eq_hits hold", int'(eq_hits),  255);
    repeat (2) @(posedge clk); #1;
    check("cnt pop no change", int'(eq_hits), 255);
    check_outs("cnt drained", 0, 0, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("cnt clr eq_hits 2",  int'(eq_hits),  0);
    check("cnt clr neq_hits 2", int'(neq_hits), 0);
    drive(0, 0, 0, 0, 0);
`endif

    // reset mid-stream at level 2
    drive(0, 1, 1, 0, 0);
    @(posedge clk); #1;
    drive(0, 1, 0, 1, 0);
    @(posedge clk); #1;
    check("mid level2", int'(level), 2);
    #2 rst_n = 1'b0;
    #1;
    check_outs("mid reset", 0, 0, 1, 0, 0);
`ifdef CMP_HIT_COUNT_EN
    check("mid reset eq_hits", int'(eq_hits), 0);
`endif
    drive(0, 1, 1, 1, 0);
    #2 rst_n = 1'b1;
    #1;
    check("mid release out_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    check_outs("mid first push", 1, 1, 1, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
